elastic_rd_ctrl: RTL and testbench
==================================

ELASTIC_RD_CTRL -- requirements
Module: elastic_rd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 10, symbol width; matches the elastic memory word.
REQ-002 Parameter BUFFER_DEPTH, 16, memory depth, power of two; ADDR = clog2(BUFFER_DEPTH).
REQ-003 Parameter START_MARK, 8, fill level required before reading starts.
REQ-004 Parameter LOW_MARK, 4, fill level at or below which a SKP symbol is inserted.
REQ-005 Parameter SKP_NEG / SKP_POS, 10'b0011110100 / 10'b1100001011, K28.0 SKP codes for RD- and RD+.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 read_clk  in  1  read-domain clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 wr_ptr_gray  in  ADDR+1  Gray-coded write pointer from the write clock domain.
REQ-010 rd_data  in  DATA_WIDTH  registered memory output (data_out).
REQ-011 read_pointer  out  ADDR  memory read address.
REQ-012 rd_en  out  1  memory read enable.
REQ-013 empty  out  1  buffer empty flag to the memory.
REQ-014 rd_ptr_gray  out  ADDR+1  registered Gray-coded read pointer for write-side full detection.
REQ-015 sym_out  out  DATA_WIDTH  symbol presented downstream.
REQ-016 sym_valid  out  1  sym_out is valid this cycle.
REQ-017 skp_inserted  out  1  one-cycle pulse; sym_out is an inserted repeat of a SKP.
REQ-018 underflow  out  1  one-cycle pulse; buffer ran empty while in RUN.

Function
REQ-019 wr_ptr_gray SHALL pass through a 2-flop synchronizer on read_clk, then be Gray-to-binary converted to wr_bin_s.
REQ-020 Read pointer rd_bin SHALL be ADDR+1 bits binary; read_pointer = rd_bin[ADDR-1:0]; wraps modulo 2*BUFFER_DEPTH.
REQ-021 fill = (wr_bin_s - rd_bin) modulo 2^(ADDR+1); empty = (fill == 0), combinational from registers.
REQ-022 rd_ptr_gray SHALL equal bin2gray(rd_bin), registered, updated the cycle after rd_bin changes.
REQ-023 The FSM SHALL have states FILL, RUN and HOLD; the reset state is FILL.
REQ-024 FILL: rd_en=0; go to RUN when fill >= START_MARK.
REQ-025 RUN: rd_en = !empty; rd_bin increments by 1 on every cycle with rd_en=1.
REQ-026 RUN with empty=1: rd_en=0, underflow=1 for one cycle, next state FILL.
REQ-027 RUN to HOLD when the fresh-symbol flag fresh=1 AND rd_data is SKP_NEG or SKP_POS AND fill <= LOW_MARK; fresh is rd_en registered by one cycle.
REQ-028 Insertion has priority over a normal read: on the RUN-to-HOLD decision cycle rd_en=0.
REQ-029 HOLD: rd_en=0, rd_bin held, unconditional return to RUN after one cycle.
REQ-030 Insertion occurs at most once per SKP: the repeated SKP has fresh=0 and SHALL NOT re-trigger HOLD.
REQ-031 sym_out = rd_data.
REQ-032 sym_valid = fresh OR (previous state was HOLD).
REQ-033 skp_inserted = 1 exactly in the cycle the repeated SKP is valid (the cycle after HOLD).
REQ-034 Latency: a symbol read with rd_en at cycle N appears with sym_valid=1 at cycle N+1.

Reset
REQ-035 With rst_n low: rd_bin=0, both synchronizer stages=0, rd_ptr_gray=0, state=FILL, fresh=0.
REQ-036 With rst_n low: rd_en=0, sym_valid=0, skp_inserted=0, underflow=0, empty=1, read_pointer=0.
REQ-037 Reset assertion mid-RUN or mid-HOLD SHALL return to FILL immediately; no pulse outputs fire on the cycle after release.

Verification
REQ-038 Write pointer steps 0..7 in Gray -> rd_en stays 0 until synced fill=8 (2 cycles after the pointer reaches 8), then rd_en=1 and read_pointer counts 0,1,2...
REQ-039 Steady state with the write pointer advancing at the read rate -> no HOLD, sym_valid continuously 1, skp_inserted=0.
REQ-040 Fill=4 and rd_data=10'b0011110100 with fresh=1 -> one HOLD cycle, read_pointer frozen one cycle, SKP appears twice on sym_out, skp_inserted=1 on the second.
REQ-041 Write pointer stalls -> after fill drains to 0, one underflow pulse, state FILL, rd_en=0 until fill >= 8.
REQ-042 Pointer wrap: run past rd_bin=31 -> rd_bin becomes 0, read_pointer 15 -> 0, rd_ptr_gray 10000 -> 00000, no spurious empty.
REQ-043 rst_n pulsed low during HOLD -> all outputs take reset values asynchronously; after release the block restarts in FILL with read_pointer=0.

Source files
------------

// File: rtl/elastic_rd_ctrl.sv
// rtl/elastic_rd_ctrl.sv - elastic buffer read-side controller with SKP insertion
module elastic_rd_ctrl #(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 16,
    parameter int START_MARK   = 8,
    parameter int LOW_MARK     = 4,
    parameter logic [DATA_WIDTH-1:0] SKP_NEG = 10'b0011110100,
    parameter logic [DATA_WIDTH-1:0] SKP_POS = 10'b1100001011,
    localparam int ADDR = $clog2(BUFFER_DEPTH)
) (
    input  logic                  read_clk,
    input  logic                  rst_n,
    input  logic [ADDR:0]         wr_ptr_gray,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR-1:0]       read_pointer,
    output logic                  rd_en,
    output logic                  empty,
    output logic [ADDR:0]         rd_ptr_gray,
    output logic [DATA_WIDTH-1:0] sym_out,
    output logic                  sym_valid,
    output logic                  skp_inserted,
    output logic                  underflow
);

    localparam logic [ADDR:0] PTR_ONE   = (ADDR+1)'(1);
    localparam logic [ADDR:0] START_LVL = (ADDR+1)'(START_MARK);
    localparam logic [ADDR:0] LOW_LVL   = (ADDR+1)'(LOW_MARK);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Gray code to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        b[ADDR] = g[ADDR];
        for (int i = ADDR - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ADDR:0] bin2gray(input logic [ADDR:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [ADDR:0] wr_sync1_q;
    logic [ADDR:0] wr_sync2_q;
    logic [ADDR:0] wr_bin_s;
    logic [ADDR:0] rd_bin_q;
    logic [ADDR:0] rd_bin_d;
    logic [ADDR:0] rd_gray_q;
    logic [ADDR:0] fill;
    state_t        state_q;
    logic          fresh_q;
    logic          was_hold_q;
    logic          is_skp;
    logic          skp_hit;
    logic          rd_en_c;
    logic          underflow_c;
    logic          go_hold;
    logic          go_fill;

    // Two-flop synchronizer bringing the write pointer into the read domain.
    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync1_q <= '0;
            wr_sync2_q <= '0;
        end else begin
            wr_sync1_q <= wr_ptr_gray;
            wr_sync2_q <= wr_sync1_q;
        end
    end

    assign wr_bin_s = gray2bin(wr_sync2_q);
    assign fill     = wr_bin_s - rd_bin_q;
    assign empty    = (fill == '0);

    // A fresh SKP at low fill earns one repeat; the repeat itself has fresh=0.
    assign is_skp  = (rd_data == SKP_NEG) || (rd_data == SKP_POS);
    assign skp_hit = fresh_q && is_skp && (fill <= LOW_LVL);

    // Read decision: underflow beats insertion, insertion beats a normal read.
    always_comb begin
        rd_en_c     = 1'b0;
        underflow_c = 1'b0;
        go_hold     = 1'b0;
        go_fill     = 1'b0;
        rd_bin_d    = rd_bin_q;
        if (state_q == ST_RUN) begin
            if (empty) begin
                underflow_c = 1'b1;
                go_fill     = 1'b1;
            end else if (skp_hit) begin
                go_hold = 1'b1;
            end else begin
                rd_en_c  = 1'b1;
                rd_bin_d = rd_bin_q + PTR_ONE;
            end
        end
    end

    // Read pointer and its Gray image, the latter lagging by one cycle.
    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= bin2gray(rd_bin_q);
        end
    end

    // FSM with registered symbol-qualifier flags.
    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            fresh_q    <= 1'b0;
            was_hold_q <= 1'b0;
        end else begin
            fresh_q    <= rd_en_c;
            was_hold_q <= (state_q == ST_HOLD);
            unique case (state_q)
                ST_FILL: begin
                    if (fill >= START_LVL) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (go_fill) begin
                        state_q <= ST_FILL;
                    end else if (go_hold) begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign read_pointer = rd_bin_q[ADDR-1:0];
    assign rd_en        = rd_en_c;
    assign underflow    = underflow_c;
    assign rd_ptr_gray  = rd_gray_q;
    assign sym_out      = rd_data;
    assign sym_valid    = fresh_q | was_hold_q;
    assign skp_inserted = was_hold_q;

endmodule

// File: tb/tb_elastic_rd_ctrl.sv
// tb/tb_elastic_rd_ctrl.sv - directed self-checking bench for elastic_rd_ctrl
module tb_elastic_rd_ctrl;

    localparam logic [9:0] SKP_N = 10'b0011110100;
    localparam logic [9:0] SKP_P = 10'b1100001011;

    logic       read_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] wr_ptr_gray = '0;
    logic [9:0] rd_data = '0;
    logic [3:0] read_pointer;
    logic       rd_en;
    logic       empty;
    logic [4:0] rd_ptr_gray;
    logic [9:0] sym_out;
    logic       sym_valid;
    logic       skp_inserted;
    logic       underflow;

    logic [9:0] mem [16];
    logic [4:0] wr_bin;
    logic [4:0] rb;
    logic [4:0] prev_rb;
    int n_checks = 0;
    int n_errors = 0;

    always #5 read_clk = ~read_clk;

    elastic_rd_ctrl dut (
        .read_clk     (read_clk),
        .rst_n        (rst_n),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_data      (rd_data),
        .read_pointer (read_pointer),
        .rd_en        (rd_en),
        .empty        (empty),
        .rd_ptr_gray  (rd_ptr_gray),
        .sym_out      (sym_out),
        .sym_valid    (sym_valid),
        .skp_inserted (skp_inserted),
        .underflow    (underflow)
    );

    // Memory model with registered output
    always @(posedge read_clk) begin
        if (rd_en) rd_data <= mem[read_pointer];
    end

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge read_clk);
        #1;
    endtask

    task automatic set_wr(input int v);
        wr_bin      = v[4:0];
        wr_ptr_gray = wr_bin ^ (wr_bin >> 1);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 10'h155 + 10'(a);
        mem[3]  = SKP_P;
        mem[11] = SKP_N;

        // Reset state
        rst_n = 1'b0;
        set_wr(0);
        tick();
        tick();
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_sym_valid", sym_valid, 1'b0);
        check("rst_skp", skp_inserted, 1'b0);
        check("rst_underflow", underflow, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_rp", read_pointer, 4'd0);
        check("rst_gray", rd_ptr_gray, 5'd0);
        rst_n = 1'b1;

        // Fill up to START_MARK
        for (int v = 1; v <= 8; v++) begin
            set_wr(v);
            tick();
            check("fill_rd_en", rd_en, 1'b0);
            if (v == 1) check("fill_empty_early", empty, 1'b1);
        end
        tick();
        check("fill8_rd_en", rd_en, 1'b0);
        check("fill8_empty", empty, 1'b0);
        tick();
        check("start_rd_en", rd_en, 1'b1);
        check("start_rp", read_pointer, 4'd0);

        // Steady state with write advancing at read rate, through pointer wrap
        rb = 5'd0;
        prev_rb = 5'd0;
        for (int i = 0; i < 40; i++) begin
            check("ss_rp", read_pointer, rb[3:0]);
            check("ss_rd_en", rd_en, 1'b1);
            check("ss_empty", empty, 1'b0);
            check("ss_underflow", underflow, 1'b0);
            check("ss_skp", skp_inserted, 1'b0);
            check("ss_gray", rd_ptr_gray, b2g(prev_rb));
            check("ss_valid", sym_valid, (i != 0));
            if (i != 0) check("ss_sym", sym_out, mem[prev_rb[3:0]]);
            if (i == 32) check("wrap_gray31", rd_ptr_gray, 5'b10000);
            if (i == 33) check("wrap_gray0", rd_ptr_gray, 5'b00000);
            set_wr(8 + i + 1);
            tick();
            prev_rb = rb;
            rb = rb + 5'd1;
        end

        // Drain toward LOW_MARK; fresh SKP_NEG arrives with fill=4
        check("drain_rp8", read_pointer, 4'd8);
        tick();
        tick();
        tick();
        check("drain_rp11", read_pointer, 4'd11);
        tick();
        check("skp_decide_rd_en", rd_en, 1'b0);
        check("skp_decide_rp", read_pointer, 4'd12);
        check("skp_first_sym", sym_out, SKP_N);
        check("skp_first_valid", sym_valid, 1'b1);
        check("skp_first_flag", skp_inserted, 1'b0);
        tick();
        check("hold_rp", read_pointer, 4'd12);
        check("hold_rd_en", rd_en, 1'b0);
        check("hold_valid", sym_valid, 1'b0);
        tick();
        check("rep_rp", read_pointer, 4'd12);
        check("rep_rd_en", rd_en, 1'b1);
        check("rep_valid", sym_valid, 1'b1);
        check("rep_flag", skp_inserted, 1'b1);
        check("rep_sym", sym_out, SKP_N);
        tick();
        check("post_rp", read_pointer, 4'd13);
        check("post_sym", sym_out, mem[12]);
        check("post_flag", skp_inserted, 1'b0);
        check("post_valid", sym_valid, 1'b1);

        // Write stalled: drain to empty and underflow
        tick();
        tick();
        tick();
        check("uf_pulse", underflow, 1'b1);
        check("uf_empty", empty, 1'b1);
        check("uf_rd_en", rd_en, 1'b0);
        check("uf_rp", read_pointer, 4'd0);
        check("uf_sym", sym_out, mem[15]);
        check("uf_gray", rd_ptr_gray, 5'b01000);
        tick();
        check("uf_after_pulse", underflow, 1'b0);
        check("uf_after_rd_en", rd_en, 1'b0);
        check("uf_after_valid", sym_valid, 1'b0);

        // Refill: fill 7 must not start reading, fill 8 must
        set_wr(55);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("refill7_rd_en", rd_en, 1'b0);
        end
        check("refill7_empty", empty, 1'b0);
        set_wr(56);
        tick();
        check("refill8_rd_en_a", rd_en, 1'b0);
        tick();
        check("refill8_rd_en_b", rd_en, 1'b0);
        tick();
        check("restart_rd_en", rd_en, 1'b1);
        check("restart_rp", read_pointer, 4'd0);

        // Second SKP (SKP_POS) leads into HOLD, then reset mid-HOLD
        tick();
        tick();
        tick();
        tick();
        check("skp2_rd_en", rd_en, 1'b0);
        check("skp2_sym", sym_out, SKP_P);
        check("skp2_rp", read_pointer, 4'd4);
        tick();
        check("hold2_rp", read_pointer, 4'd4);
        check("hold2_rd_en", rd_en, 1'b0);
        rst_n = 1'b0;
        set_wr(0);
        #1;
        check("arst_rd_en", rd_en, 1'b0);
        check("arst_valid", sym_valid, 1'b0);
        check("arst_skp", skp_inserted, 1'b0);
        check("arst_underflow", underflow, 1'b0);
        check("arst_empty", empty, 1'b1);
        check("arst_rp", read_pointer, 4'd0);
        check("arst_gray", rd_ptr_gray, 5'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_skp", skp_inserted, 1'b0);
        check("rel_valid", sym_valid, 1'b0);
        check("rel_underflow", underflow, 1'b0);
        check("rel_rd_en", rd_en, 1'b0);
        check("rel_rp", read_pointer, 4'd0);
        set_wr(8);
        tick();
        check("rel_fill_a", rd_en, 1'b0);
        tick();
        check("rel_fill_b", rd_en, 1'b0);
        tick();
        check("rel_run_rd_en", rd_en, 1'b1);
        check("rel_run_rp", read_pointer, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
